ibex_rf_access_ctrl: RTL and testbench
======================================

Name: ibex_rf_access_ctrl

Overview:
- Initiator/arbiter that drives the register file's read port A and write port from a debug/test request channel while the core is halted.
- Transparent pass-through of core read/write signals at all other times.
- Sits between ID/WB stages, the debug module access path and the register file.
- Sequences single-word accesses and returns read data, or an error, on a one-cycle response strobe.

Parameters:
- RV32E, 0: when 1, register addresses 16-31 are invalid (error, no access).
- DataWidth, 32: register word width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- core_halted_i  in  1  core stalled in debug mode; requests accepted only when 1.
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle (combinational).
- we_i  in  1  request is a write.
- addr_i  in  5  register address.
- wdata_i  in  DataWidth  write data.
- rvalid_o  out  1  response valid (one-cycle pulse).
- rdata_o  out  DataWidth  read data; 0 for writes and errored reads.
- err_o  out  1  response error, qualified by rvalid_o.
- core_raddr_a_i  in  5  core read address A.
- core_waddr_a_i  in  5  core write address.
- core_wdata_a_i  in  DataWidth  core write data.
- core_we_a_i  in  1  core write enable.
- rf_raddr_a_o  out  5  register file read address A.
- rf_rdata_a_i  in  DataWidth  register file read data A.
- rf_waddr_a_o  out  5  register file write address.
- rf_wdata_a_o  out  DataWidth  register file write data.
- rf_we_a_o  out  1  register file write enable.
- rf_err_i  in  1  register file glitch/one-hot error flag.

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE.
  - gnt_o, rvalid_o, err_o = 0; rdata_o = 0.
  - All request registers cleared.
  - Applies mid-access: any in-flight access is abandoned and no response is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - gnt_o = req_i & core_halted_i & ~core_we_a_i.
  - On gnt_o: latch we_i, addr_i, wdata_i into addr_q/we_q/wdata_q; compute inv_q = RV32E & addr_i[4]; go to ACCESS.
  - Requests while not halted are held off (gnt_o=0); req_i may remain asserted.
- ACCESS (exactly 1 cycle):
  - Read, valid address: rf_raddr_a_o = addr_q; rdata_q <= rf_rdata_a_i at the clock edge.
  - Write, valid address, addr_q != 0: rf_we_a_o = 1, rf_waddr_a_o = addr_q, rf_wdata_a_o = wdata_q.
  - Write to x0: no rf_we_a_o, no error.
  - inv_q = 1: no register file activity; rdata_q <= 0.
  - err_q <= inv_q | rf_err_i | (core_we_a_i & we_q).
  - Collision: if core_we_a_i is asserted in ACCESS, the core write wins and the request write is dropped.
  - Go to RESP unconditionally; a drop of core_halted_i during ACCESS does not abort.
- RESP (1 cycle):
  - rvalid_o = 1; rdata_o = rdata_q for reads, 0 for writes.
  - err_o = err_q; an errored read returns rdata_o = 0.
  - Next state IDLE; gnt_o = 0 in RESP.
- Outside ACCESS: rf_* outputs = core_* inputs (pure pass-through, zero added latency).
- Timing:
  - gnt at cycle T, ACCESS at T+1, rvalid_o at T+2.
  - Maximum throughput one access per 3 cycles.
  - rdata_o, rvalid_o and err_o are registered outputs.
- A write is visible to a subsequent read request (next ACCESS reads the updated register).

Decomposition:
- Shared ibex_pkg: typedef enum logic [1:0] rf_acc_state_e {RfAccIdle, RfAccAccess, RfAccResp}.
- Address-width constant RegAddrW = 5 in ibex_pkg.
- Single module; no sub-module needed; the register-file port mux is inline.

Test Plan:
- Halted, write x5 = 0xDEADBEEF, then read x5 -> gnt at T; rf_we_a_o=1 with waddr 5 at T+1; rvalid_o at T+2 with err_o=0; the read returns rdata_o=0xDEADBEEF, err_o=0.
- core_halted_i=0, req_i=1 held for 10 cycles, then halt -> gnt_o=0 throughout, gnt_o=1 on the first halted cycle; core_we_a_i/core_waddr_a_i=3 pass through to rf_* unchanged meanwhile.
- RV32E=1, read x20 -> no rf access, rvalid_o=1, err_o=1, rdata_o=0; write x0 = 0x1234 -> rf_we_a_o never 1, err_o=0.
- Write x7 with core_we_a_i=1 (waddr 9) asserted during ACCESS -> rf_we_a_o from the core with waddr 9; err_o=1 on response.
- rf_err_i=1 during a read ACCESS -> err_o=1 at RESP.
- rst_i pulsed in ACCESS -> rvalid_o never asserts, all outputs 0, IDLE; the next request completes normally.

Source files
------------

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared register-file access controller types and constants.
package ibex_pkg;
    localparam int RegAddrW = 5;
    typedef enum logic [1:0] {RfAccIdle, RfAccAccess, RfAccResp} rf_acc_state_e;
endpackage

// File: rtl/ibex_rf_access_ctrl.sv
// ibex_rf_access_ctrl: debug-time register file access sequencer with core pass-through.
module ibex_rf_access_ctrl
    import ibex_pkg::*;
#(
    parameter bit RV32E     = 1'b0,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 core_halted_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [RegAddrW-1:0]  addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o,
    input  logic [RegAddrW-1:0]  core_raddr_a_i,
    input  logic [RegAddrW-1:0]  core_waddr_a_i,
    input  logic [DataWidth-1:0] core_wdata_a_i,
    input  logic                 core_we_a_i,
    output logic [RegAddrW-1:0]  rf_raddr_a_o,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    output logic [RegAddrW-1:0]  rf_waddr_a_o,
    output logic [DataWidth-1:0] rf_wdata_a_o,
    output logic                 rf_we_a_o,
    input  logic                 rf_err_i
);
    rf_acc_state_e state, state_next;
    logic [RegAddrW-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q, rdata_q;
    logic we_q, inv_q, err_q, access, acc_wr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= RfAccIdle;
        else state <= state_next;
    end

    always_comb begin
        state_next = (state == RfAccIdle) ? (gnt_o ? RfAccAccess : RfAccIdle) :
                     (state == RfAccAccess) ? RfAccResp : RfAccIdle;
    end

    // A core write in ACCESS takes the write port; the request write is dropped.
    always_comb begin
        gnt_o        = (state == RfAccIdle) & req_i & core_halted_i & ~core_we_a_i & ~rst_i;
        access       = (state == RfAccAccess);
        acc_wr       = access & we_q & ~inv_q & (|addr_q) & ~core_we_a_i;
        rf_raddr_a_o = (access & ~we_q & ~inv_q) ? addr_q : core_raddr_a_i;
        rf_we_a_o    = core_we_a_i | acc_wr;
        rf_waddr_a_o = acc_wr ? addr_q : core_waddr_a_i;
        rf_wdata_a_o = acc_wr ? wdata_q : core_wdata_a_i;
        rvalid_o     = (state == RfAccResp);
        err_o        = rvalid_o & err_q;
        rdata_o      = (rvalid_o & ~err_q) ? rdata_q : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            inv_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (gnt_o) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            inv_q   <= RV32E & addr_i[RegAddrW-1];
        end else if (access) begin
            rdata_q <= (we_q | inv_q) ? '0 : rf_rdata_a_i;
            err_q   <= inv_q | rf_err_i | (core_we_a_i & we_q);
        end
    end
endmodule

// File: tb/tb_ibex_rf_access_ctrl.sv
// tb_ibex_rf_access_ctrl: table-driven and randomized check against a register-array model.
module tb_ibex_rf_access_ctrl;
    localparam bit E = 1'b1;

    logic clk = 1'b0;
    logic rst_i, core_halted_i, req_i, gnt_o, we_i, rvalid_o, err_o;
    logic [4:0] addr_i, core_raddr_a_i, core_waddr_a_i, rf_raddr_a_o, rf_waddr_a_o;
    logic [31:0] wdata_i, rdata_o, core_wdata_a_i, rf_rdata_a_i, rf_wdata_a_o;
    logic core_we_a_i, rf_we_a_o, rf_err_i;

    logic [31:0] rf [32] = '{default: '0};
    logic [31:0] mem [32] = '{default: '0};
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic w; logic [4:0] a; logic [31:0] d;
        logic cwe; logic [4:0] cwa; logic rfe; int e;
    } vec_t;
    vec_t tbl[12];

    ibex_rf_access_ctrl #(.RV32E(E), .DataWidth(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .core_halted_i(core_halted_i),
        .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .core_raddr_a_i(core_raddr_a_i), .core_waddr_a_i(core_waddr_a_i),
        .core_wdata_a_i(core_wdata_a_i), .core_we_a_i(core_we_a_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_rdata_a_i(rf_rdata_a_i),
        .rf_waddr_a_o(rf_waddr_a_o), .rf_wdata_a_o(rf_wdata_a_o),
        .rf_we_a_o(rf_we_a_o), .rf_err_i(rf_err_i)
    );

    always #5 clk = ~clk;

    // Environment register file: x0 hardwired to zero.
    assign rf_rdata_a_i = rf[rf_raddr_a_o];
    always @(posedge clk) if (rf_we_a_o && rf_waddr_a_o != 5'd0) rf[rf_waddr_a_o] <= rf_wdata_a_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // te < 0: expected error comes from the model, otherwise from the table.
    task automatic txn(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic cwe, input logic [4:0] cwa, input logic rfe, input int te);
        logic [31:0] cwd, exp_rd;
        logic inv, exp_err, exp_we;
        int k;
        cwd = $urandom;
        req_i = 1; we_i = w; addr_i = a; wdata_i = d; core_halted_i = 1; core_we_a_i = 0;
        #1;
        k = 0;
        while (!gnt_o && k < 20) begin step(); k++; end
        chk("gnt", {31'd0, gnt_o}, 1);
        chk("rvalid_at_gnt", {31'd0, rvalid_o}, 0);
        step();
        req_i = 0; core_we_a_i = cwe; core_waddr_a_i = cwa; core_wdata_a_i = cwd; rf_err_i = rfe;
        #1;
        inv = E & a[4];
        exp_we = w & !inv & (a != 5'd0);
        chk("acc_we", {31'd0, rf_we_a_o}, {31'd0, cwe | exp_we});
        if (cwe) begin
            chk("acc_waddr_core", {27'd0, rf_waddr_a_o}, {27'd0, cwa});
            chk("acc_wdata_core", rf_wdata_a_o, cwd);
        end else if (exp_we) begin
            chk("acc_waddr", {27'd0, rf_waddr_a_o}, {27'd0, a});
            chk("acc_wdata", rf_wdata_a_o, d);
        end
        if (!w && !inv) chk("acc_raddr", {27'd0, rf_raddr_a_o}, {27'd0, a});
        chk("rvalid_acc", {31'd0, rvalid_o}, 0);
        exp_err = (te < 0) ? (inv | rfe | (cwe & w)) : te[0];
        exp_rd = (w || exp_err) ? 32'd0 : mem[a];
        if (cwe) begin
            if (cwa != 5'd0) mem[cwa] = cwd;
        end else if (exp_we) mem[a] = d;
        step();
        core_we_a_i = 0; rf_err_i = 0; req_i = 1;
        #1;
        chk("rvalid_resp", {31'd0, rvalid_o}, 1);
        chk("err_resp", {31'd0, err_o}, {31'd0, exp_err});
        chk("rdata_resp", rdata_o, exp_rd);
        chk("gnt_resp", {31'd0, gnt_o}, 0);
        req_i = 0;
        step();
        chk("rvalid_idle", {31'd0, rvalid_o}, 0);
        chk("rdata_idle", rdata_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 0, 0};
        tbl[1]  = '{0, 5'd5,  32'h0,        0, 5'd0, 0, 0};
        tbl[2]  = '{0, 5'd20, 32'h0,        0, 5'd0, 0, 1};
        tbl[3]  = '{1, 5'd0,  32'h1234,     0, 5'd0, 0, 0};
        tbl[4]  = '{0, 5'd0,  32'h0,        0, 5'd0, 0, 0};
        tbl[5]  = '{1, 5'd7,  32'hABCD0123, 1, 5'd9, 0, 1};
        tbl[6]  = '{0, 5'd9,  32'h0,        0, 5'd0, 0, 0};
        tbl[7]  = '{0, 5'd7,  32'h0,        0, 5'd0, 0, 0};
        tbl[8]  = '{0, 5'd5,  32'h0,        0, 5'd0, 1, 1};
        tbl[9]  = '{1, 5'd20, 32'h77777777, 0, 5'd0, 0, 1};
        tbl[10] = '{1, 5'd3,  32'h55AA55AA, 0, 5'd0, 0, 0};
        tbl[11] = '{0, 5'd3,  32'h0,        0, 5'd0, 0, 0};

        rst_i = 1; core_halted_i = 1; req_i = 1; we_i = 0; addr_i = 0; wdata_i = 0;
        core_raddr_a_i = 0; core_waddr_a_i = 0; core_wdata_a_i = 0; core_we_a_i = 0; rf_err_i = 0;
        #1;
        chk("rst_gnt", {31'd0, gnt_o}, 0);
        chk("rst_rvalid", {31'd0, rvalid_o}, 0);
        chk("rst_err", {31'd0, err_o}, 0);
        chk("rst_rdata", rdata_o, 0);
        step(); step();
        rst_i = 0; req_i = 0;
        step();

        foreach (tbl[i]) txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].cwe, tbl[i].cwa, tbl[i].rfe, tbl[i].e);

        // Held-off request while running; core traffic passes straight through.
        core_halted_i = 0; req_i = 1; we_i = 0; addr_i = 5'd5;
        core_we_a_i = 1; core_waddr_a_i = 5'd3; core_raddr_a_i = 5'd11;
        for (int i = 0; i < 10; i++) begin
            core_wdata_a_i = $urandom;
            #1;
            chk("hold_gnt", {31'd0, gnt_o}, 0);
            chk("hold_we", {31'd0, rf_we_a_o}, 1);
            chk("hold_waddr", {27'd0, rf_waddr_a_o}, 3);
            chk("hold_wdata", rf_wdata_a_o, core_wdata_a_i);
            chk("hold_raddr", {27'd0, rf_raddr_a_o}, 11);
            mem[3] = core_wdata_a_i;
            step();
        end
        core_we_a_i = 0; core_halted_i = 1;
        #1;
        chk("halt_gnt", {31'd0, gnt_o}, 1);
        step();
        req_i = 0;
        step();
        chk("halt_rvalid", {31'd0, rvalid_o}, 1);
        chk("halt_rdata", rdata_o, mem[5]);
        step();

        // Reset pulsed during ACCESS abandons the access without a response.
        req_i = 1; we_i = 0; addr_i = 5'd5;
        #1;
        chk("ra_gnt", {31'd0, gnt_o}, 1);
        step();
        rst_i = 1;
        #1;
        chk("ra_gnt_rst", {31'd0, gnt_o}, 0);
        chk("ra_rvalid", {31'd0, rvalid_o}, 0);
        chk("ra_err", {31'd0, err_o}, 0);
        chk("ra_rdata", rdata_o, 0);
        step();
        rst_i = 0; req_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ra_no_resp", {31'd0, rvalid_o}, 0);
            step();
        end
        txn(0, 5'd5, 32'd0, 0, 5'd0, 0, -1);

        for (int i = 0; i < 60; i++)
            txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 5) == 0, 5'($urandom_range(1, 31)),
                $urandom_range(0, 7) == 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
